// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized rxd, 16x oversampling driven by tick16.
// Optional even-parity stage compiled in with `define UART_RX_PARITY_EN.
module uart_rx #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 tick16,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  localparam logic [2:0] LP_LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [3:0] LP_MID_START = 4'd7;
  localparam logic [3:0] LP_MID_BIT   = 4'd15;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_sync3;
  logic [3:0]           r_cnt;
  logic [3:0]           w_cnt_nxt;
  logic [2:0]           r_bit;
  logic [2:0]           w_bit_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic [DATA_BITS-1:0] r_data;
  logic [DATA_BITS-1:0] w_data_nxt;
  logic                 r_valid;
  logic                 w_valid_nxt;
  logic                 r_ferr;
  logic                 w_ferr_nxt;
  logic                 w_rx;
  logic                 w_fall;
`ifdef UART_RX_PARITY_EN
  logic                 r_pbad;
  logic                 w_pbad_nxt;
  logic                 r_perr;
  logic                 w_perr_nxt;

  // Even parity: data bits plus parity bit must hold an even number of ones.
  function automatic logic f_parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction
`endif

  assign w_rx       = r_sync2;
  assign w_fall     = r_sync3 & ~r_sync2;
  assign busy       = (r_state != S_IDLE);
  assign data       = r_data;
  assign data_valid = r_valid;
  assign frame_err  = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr;
`endif

  // Synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // Next-state and datapath decode; everything advances only on tick16 outside IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_pbad_nxt  = r_pbad;
    w_perr_nxt  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = 4'd0;
          w_bit_nxt   = 3'd0;
`ifdef UART_RX_PARITY_EN
          w_pbad_nxt  = 1'b0;
`endif
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (tick16) begin
          if (r_cnt == LP_MID_START) begin
            w_cnt_nxt   = 4'd0;
            w_bit_nxt   = 3'd0;
            w_state_nxt = w_rx ? S_IDLE : S_DATA;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      S_DATA: begin
        if (tick16) begin
          w_cnt_nxt = r_cnt + 4'd1;
          if (r_cnt == LP_MID_BIT) begin
            w_shift_nxt = {w_rx, r_shift[DATA_BITS-1:1]};
            if (r_bit == LP_LAST_BIT) begin
              w_bit_nxt = 3'd0;
`ifdef UART_RX_PARITY_EN
              w_state_nxt = S_PARITY;
`else
              w_state_nxt = S_STOP;
`endif
            end else begin
              w_bit_nxt = r_bit + 3'd1;
            end
          end else begin
            w_shift_nxt = r_shift;
          end
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick16) begin
          w_cnt_nxt = r_cnt + 4'd1;
          if (r_cnt == LP_MID_BIT) begin
            w_pbad_nxt  = f_parity_bad(r_shift, w_rx);
            w_state_nxt = S_STOP;
          end else begin
            w_pbad_nxt = r_pbad;
          end
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
`endif
      S_STOP: begin
        if (tick16) begin
          w_cnt_nxt = r_cnt + 4'd1;
          if (r_cnt == LP_MID_BIT) begin
            // The word is published even on a bad stop bit; only the pulse differs.
            w_data_nxt  = r_shift;
            w_ferr_nxt  = ~w_rx;
            w_state_nxt = S_IDLE;
`ifdef UART_RX_PARITY_EN
            w_perr_nxt  = r_pbad;
            w_valid_nxt = w_rx & ~r_pbad;
`else
            w_valid_nxt = w_rx;
`endif
          end else begin
            w_data_nxt = r_data;
          end
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
        w_bit_nxt   = 3'd0;
      end
    endcase
  end

  // State, counters, shift register and registered output pulses.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_bit   <= 3'd0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_pbad  <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
      r_pbad  <= w_pbad_nxt;
      r_perr  <= w_perr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx; frame outcomes come from a
// behavioural model of the line protocol (optional parity via UART_RX_PARITY_EN).
module tb_uart_rx;
  localparam int DB       = 8;
  localparam int TICK_DIV = 5;

  logic          clk_in = 1'b0;
  logic          reset  = 1'b1;
  logic          tick16 = 1'b0;
  logic          rxd    = 1'b1;
  logic [DB-1:0] data;
  logic          data_valid;
  logic          frame_err;
  logic          busy;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
  logic          par_flip = 1'b0;
  int            perr_cnt = 0;
  logic          prev_p   = 1'b0;
`endif

  int            n_checks  = 0;
  int            n_pass    = 0;
  logic          tick_en   = 1'b1;
  int            valid_cnt = 0;
  int            ferr_cnt  = 0;
  int            width_err = 0;
  logic          prev_v    = 1'b0;
  logic          prev_f    = 1'b0;
  logic [DB-1:0] got_q[$];

  uart_rx #(.DATA_BITS(DB)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .tick16     (tick16),
    .rxd        (rxd),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk_in = ~clk_in;

  // 16x baud enable: one clk_in cycle out of every TICK_DIV, gated by tick_en.
  initial begin
    forever begin
      repeat (TICK_DIV - 1) @(posedge clk_in);
      #1 tick16 = tick_en;
      @(posedge clk_in);
      #1 tick16 = 1'b0;
    end
  end

  // Pulse monitor: counts pulses, records published words, flags pulses wider than one cycle.
  initial begin
    forever begin
      @(negedge clk_in);
      if (data_valid === 1'b1) begin
        valid_cnt++;
        got_q.push_back(data);
      end
      if (frame_err === 1'b1) ferr_cnt++;
      if (data_valid === 1'b1 && prev_v) width_err++;
      if (frame_err === 1'b1 && prev_f) width_err++;
      prev_v = (data_valid === 1'b1);
      prev_f = (frame_err === 1'b1);
`ifdef UART_RX_PARITY_EN
      if (parity_err === 1'b1) perr_cnt++;
      if (parity_err === 1'b1 && prev_p) width_err++;
      prev_p = (parity_err === 1'b1);
`endif
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      while (tick16 !== 1'b1) @(posedge clk_in);
    end
    #2;
  endtask

  task automatic clear_mon();
    valid_cnt = 0;
    ferr_cnt  = 0;
    got_q.delete();
`ifdef UART_RX_PARITY_EN
    perr_cnt  = 0;
`endif
  endtask

  // One frame on the line, 16 ticks per bit; rxd is left at the stop-bit level.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit);
    rxd = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < DB; i++) begin
      rxd = d[i];
      wait_ticks(16);
    end
`ifdef UART_RX_PARITY_EN
    rxd = (^d) ^ par_flip;
    wait_ticks(16);
`endif
    rxd = stop_bit;
    wait_ticks(16);
  endtask

  // Reference outcome of a frame: the word is always published; the pulse depends on stop/parity.
  task automatic expect_frame(input string tag, input logic [DB-1:0] d, input logic stop_bit);
    int exp_valid;
    int exp_ferr;
    int exp_perr;
    exp_perr = 0;
`ifdef UART_RX_PARITY_EN
    exp_perr = (($countones(d) + ((^d) ^ par_flip)) % 2 != 0) ? 1 : 0;
    chk({tag, "_perr"}, 32'(perr_cnt), 32'(exp_perr));
`endif
    exp_ferr  = stop_bit ? 0 : 1;
    exp_valid = (stop_bit && exp_perr == 0) ? 1 : 0;
    chk({tag, "_valid"}, 32'(valid_cnt), 32'(exp_valid));
    chk({tag, "_ferr"},  32'(ferr_cnt),  32'(exp_ferr));
    chk({tag, "_data"},  32'(data),      32'(d));
    chk({tag, "_busy"},  32'(busy),      32'd0);
  endtask

  task automatic run_frame(input string tag, input logic [DB-1:0] d, input logic stop_bit);
    clear_mon();
    send_frame(d, stop_bit);
    rxd = 1'b1;
    wait_ticks(4);
    expect_frame(tag, d, stop_bit);
  endtask

  initial begin
    logic [DB-1:0] rd;
    logic          rs;
    logic [31:0]   g0;
    logic [31:0]   g1;

    reset = 1'b1;
    rxd   = 1'b1;
    repeat (3) @(posedge clk_in);
    #2;
    chk("rst_data",  32'(data),       32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_ferr",  32'(frame_err),  32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    reset = 1'b0;
    wait_ticks(4);

    run_frame("f55", 8'h55, 1'b1);

    // Short low glitch: START must abort at its mid-bit sample.
    clear_mon();
    rxd = 1'b0;
    wait_ticks(2);
    chk("glitch_busy_in", 32'(busy), 32'd1);
    wait_ticks(2);
    rxd = 1'b1;
    wait_ticks(12);
    chk("glitch_busy_out", 32'(busy),      32'd0);
    chk("glitch_valid",    32'(valid_cnt), 32'd0);
    chk("glitch_ferr",     32'(ferr_cnt),  32'd0);

    // Bad stop bit, line then held low: no re-arm until a fresh falling edge.
    clear_mon();
    send_frame(8'hA3, 1'b0);
    wait_ticks(32);
    expect_frame("fA3_ferr", 8'hA3, 1'b0);
    rxd = 1'b1;
    wait_ticks(4);
    run_frame("f0F_after", 8'h0F, 1'b1);

    // Back-to-back frames, no idle gap.
    clear_mon();
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    rxd = 1'b1;
    wait_ticks(4);
    g0 = (got_q.size() > 0) ? 32'(got_q[0]) : 32'hDEAD;
    g1 = (got_q.size() > 1) ? 32'(got_q[1]) : 32'hDEAD;
    chk("b2b_count", 32'(valid_cnt), 32'd2);
    chk("b2b_first", g0, 32'hA3);
    chk("b2b_second", g1, 32'h0F);

    // Reset in the middle of bit 3 of 0xFF.
    clear_mon();
    rxd = 1'b0;
    wait_ticks(16);
    rxd = 1'b1;
    wait_ticks(56);
    reset = 1'b1;
    #1;
    chk("midrst_data",  32'(data),       32'd0);
    chk("midrst_busy",  32'(busy),       32'd0);
    chk("midrst_valid", 32'(data_valid), 32'd0);
    repeat (2) @(posedge clk_in);
    #2 reset = 1'b0;
    wait_ticks(120);
    chk("midrst_no_pulse", 32'(valid_cnt + ferr_cnt), 32'd0);
    run_frame("f3C", 8'h3C, 1'b1);

    // Freeze tick16 inside bit 3 of 0x96 and wiggle rxd; the frame must survive.
    clear_mon();
    rd  = 8'h96;
    rxd = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 3; i++) begin
      rxd = rd[i];
      wait_ticks(16);
    end
    rxd = rd[3];
    wait_ticks(4);
    tick_en = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_in);
      #2 rxd = 1'($urandom_range(0, 1));
    end
    chk("freeze_busy",  32'(busy),                 32'd1);
    chk("freeze_pulse", 32'(valid_cnt + ferr_cnt), 32'd0);
    rxd = rd[3];
    tick_en = 1'b1;
    wait_ticks(12);
    for (int i = 4; i < DB; i++) begin
      rxd = rd[i];
      wait_ticks(16);
    end
`ifdef UART_RX_PARITY_EN
    rxd = ^rd;
    wait_ticks(16);
`endif
    rxd = 1'b1;
    wait_ticks(20);
    expect_frame("freeze", rd, 1'b1);

`ifdef UART_RX_PARITY_EN
    par_flip = 1'b1;
    run_frame("par07_bad", 8'h07, 1'b1);
    par_flip = 1'b0;
    run_frame("par07_ok", 8'h07, 1'b1);
`endif

    for (int k = 0; k < 16; k++) begin
      rd = DB'($urandom);
      rs = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
      par_flip = ($urandom_range(0, 3) == 0);
`endif
      run_frame($sformatf("rnd%0d", k), rd, rs);
      wait_ticks($urandom_range(0, 6));
    end

    chk("pulse_width", 32'(width_err), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: DATA_BITS, 8, number of data bits per frame (5..8).
REQ-002 Port: clk_in  input  1  system clock; all logic on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: tick16  input  1  single-cycle enable at 16x baud, from the baud divider stage.
REQ-005 Port: rxd  input  1  asynchronous serial line, idle high.
REQ-006 Port: data  output  DATA_BITS  last received word, LSB first on the line.
REQ-007 Port: data_valid  output  1  one clk_in cycle pulse: good frame received.
REQ-008 Port: frame_err  output  1  one clk_in cycle pulse: stop bit sampled low.
REQ-009 Port: busy  output  1  high whenever state is not IDLE.
REQ-010 Port: parity_err  output  1  one-cycle pulse on parity mismatch (present only with PARITY_EN).

Function
REQ-011 rxd SHALL pass a 2-flop synchronizer; flops reset to 1; all sampling uses the synchronized value.
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY (PARITY_EN only), STOP.
REQ-013 A 4-bit tick counter SHALL advance only on clk_in edges where tick16=1; wraps 15->0.
REQ-014 IDLE: synchronized falling edge (1 then 0) SHALL enter START with counter=0.
REQ-015 START: on the tick where counter==7, line sampled; low -> DATA, counter=0, bit index=0; high -> IDLE (false start, no pulses).
REQ-016 DATA: on the tick where counter==15 (mid-bit), sample SHALL shift into the data register LSB first; after DATA_BITS samples -> PARITY if enabled, else STOP.
REQ-017 PARITY: sampled at counter==15; even parity over data bits plus parity bit; -> STOP.
REQ-018 STOP: sampled at counter==15; high -> data updated, data_valid pulses; low -> data updated, frame_err pulses, data_valid stays 0; either way -> IDLE.
REQ-019 With PARITY_EN, a parity mismatch SHALL pulse parity_err together with the stop result and suppress data_valid.
REQ-020 Pulses SHALL assert in the clk_in cycle after the sampling tick and last exactly one cycle.
REQ-021 data SHALL hold its value between frames and change only on the STOP sampling tick.
REQ-022 After a frame error the line is low; IDLE re-arms only on a fresh 1->0 edge, so no spurious frame starts.
REQ-023 tick16 held 0 SHALL freeze the FSM and counter; rxd changes alone SHALL not advance DATA/STOP states.
REQ-024 busy SHALL be combinationally derived from state (not IDLE).

Reset
REQ-025 reset=1 SHALL immediately force: state IDLE, counter 0, bit index 0, data 0, data_valid/frame_err/parity_err 0, synchronizer flops 1.
REQ-026 Reset asserted mid-frame SHALL discard the partial word; no pulse SHALL be emitted for it.
REQ-027 After reset release, reception begins only on the next falling edge of the synchronized rxd.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: PARITY state, parity_err port and parity check compiled in; frame = start+DATA_BITS+parity+stop.
REQ-029 Macro absent: no PARITY state, no parity_err port; frame = start+DATA_BITS+stop.

Verification
REQ-030 Frame 0x55, 16 ticks/bit, valid stop -> data=0x55, single data_valid pulse, busy low afterwards.
REQ-031 rxd low for 4 ticks then high -> START aborts at counter 7, no pulses, state IDLE.
REQ-032 Frame 0xA3 with stop bit low -> data=0xA3, frame_err one pulse, data_valid 0; next frame 0x0F received correctly once line returns high and falls again.
REQ-033 Back-to-back frames 0xA3, 0x0F (no idle gap) -> two data_valid pulses, data 0xA3 then 0x0F.
REQ-034 reset asserted during bit 3 of 0xFF -> outputs zeroed at once, no data_valid; subsequent 0x3C received as 0x3C.
REQ-035 UART_RX_PARITY_EN: 0x07 with parity bit 0 -> parity_err pulse, no data_valid; with parity bit 1 -> data_valid, data=0x07.
